// File: rtl/alarm_ring_controller.sv
// Alarm event sequencer: rising-edge trigger, 1 s on/off beep, counted snooze/timeout schedule.
// All outputs registered; inputs sampled at a clk edge are reflected one clk later.
module alarm_ring_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_armed,
  input  logic       time_match,
  input  logic       snooze_req,
  input  logic       dismiss_req,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snoozes_left
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_MIN * 60 - 1);
  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [2:0]  MAX_LEFT  = 3'(MAX_SNOOZES);

  state_t      r_state;
  logic        r_prev_match;
  logic        r_beep_phase;
  logic [7:0]  r_ring_cnt;
  logic [15:0] r_snz_cnt;
  logic        r_buzzer;
  logic        r_ringing;
  logic        r_snoozing;
  logic [2:0]  r_snoozes_left;

  logic w_trigger;
  logic w_left_nz;
  logic w_to_idle;

  assign w_trigger = time_match & ~r_prev_match;
  assign w_left_nz = (r_snoozes_left != 3'd0);
  // Disarm beats everything; dismiss only matters once an event is in progress.
  assign w_to_idle = ~alarm_armed | ((r_state != ST_IDLE) & dismiss_req);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_prev_match   <= 1'b1;
      r_beep_phase   <= 1'b0;
      r_ring_cnt     <= 8'd0;
      r_snz_cnt      <= 16'd0;
      r_buzzer       <= 1'b0;
      r_ringing      <= 1'b0;
      r_snoozing     <= 1'b0;
      r_snoozes_left <= MAX_LEFT;
    end else begin
      r_prev_match <= time_match;
      if (w_to_idle) begin
        r_state        <= ST_IDLE;
        r_beep_phase   <= 1'b0;
        r_ring_cnt     <= 8'd0;
        r_snz_cnt      <= 16'd0;
        r_buzzer       <= 1'b0;
        r_ringing      <= 1'b0;
        r_snoozing     <= 1'b0;
        r_snoozes_left <= MAX_LEFT;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_trigger) begin
              r_state      <= ST_RINGING;
              r_ring_cnt   <= 8'd0;
              r_beep_phase <= 1'b1;
              r_buzzer     <= 1'b1;
              r_ringing    <= 1'b1;
              r_snoozing   <= 1'b0;
            end
          end

          ST_RINGING: begin
            if (snooze_req && w_left_nz) begin
              r_state        <= ST_SNOOZE;
              r_snz_cnt      <= 16'd0;
              r_beep_phase   <= 1'b0;
              r_buzzer       <= 1'b0;
              r_ringing      <= 1'b0;
              r_snoozing     <= 1'b1;
              r_snoozes_left <= r_snoozes_left - 3'd1;
            end else if (tick_1hz) begin
              if (r_ring_cnt == RING_LAST) begin
                // Unattended: fall back to a snooze while any remain, otherwise give up.
                r_beep_phase <= 1'b0;
                r_buzzer     <= 1'b0;
                r_ringing    <= 1'b0;
                r_ring_cnt   <= 8'd0;
                if (w_left_nz) begin
                  r_state        <= ST_SNOOZE;
                  r_snz_cnt      <= 16'd0;
                  r_snoozing     <= 1'b1;
                  r_snoozes_left <= r_snoozes_left - 3'd1;
                end else begin
                  r_state        <= ST_IDLE;
                  r_snz_cnt      <= 16'd0;
                  r_snoozing     <= 1'b0;
                  r_snoozes_left <= MAX_LEFT;
                end
              end else begin
                r_ring_cnt   <= r_ring_cnt + 8'd1;
                r_beep_phase <= ~r_beep_phase;
                r_buzzer     <= ~r_beep_phase;
              end
            end
          end

          ST_SNOOZE: begin
            if (tick_1hz) begin
              if (r_snz_cnt == SNZ_LAST) begin
                r_state      <= ST_RINGING;
                r_ring_cnt   <= 8'd0;
                r_beep_phase <= 1'b1;
                r_buzzer     <= 1'b1;
                r_ringing    <= 1'b1;
                r_snoozing   <= 1'b0;
              end else begin
                r_snz_cnt <= r_snz_cnt + 16'd1;
              end
            end
          end

          default: begin
            r_state        <= ST_IDLE;
            r_beep_phase   <= 1'b0;
            r_ring_cnt     <= 8'd0;
            r_snz_cnt      <= 16'd0;
            r_buzzer       <= 1'b0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
            r_snoozes_left <= MAX_LEFT;
          end
        endcase
      end
    end
  end

  assign buzzer       = r_buzzer;
  assign ringing      = r_ringing;
  assign snoozing     = r_snoozing;
  assign snoozes_left = r_snoozes_left;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller with SNOOZE_MIN=1, RING_TIMEOUT_S=4, MAX_SNOOZES=2.
module tb_alarm_ring_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       alarm_armed;
  logic       time_match;
  logic       snooze_req;
  logic       dismiss_req;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snoozes_left;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_ring_controller #(
    .SNOOZE_MIN    (1),
    .RING_TIMEOUT_S(4),
    .MAX_SNOOZES   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .alarm_armed (alarm_armed),
    .time_match  (time_match),
    .snooze_req  (snooze_req),
    .dismiss_req (dismiss_req),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snoozes_left(snoozes_left)
  );

  always #5 clk = ~clk;

  // exp = {buzzer, ringing, snoozing, snoozes_left[2:0]}
  typedef struct packed {
    logic       rst_n;
    logic       armed;
    logic       match;
    logic       snz;
    logic       dis;
    logic       tick;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic a, input logic m, input logic s,
                              input logic d, input logic t, input logic [5:0] e);
    vec_t v;
    v.rst_n = r; v.armed = a; v.match = m; v.snz = s; v.dis = d; v.tick = t; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {buzzer, ringing, snoozing, snoozes_left};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got buz/ring/snz/left=%b/%b/%b/%0d, want %b/%b/%b/%0d",
               name, act[5], act[4], act[3], act[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Drive at negedge, let one posedge pass, return at the next negedge.
  task automatic step(input logic r, input logic a, input logic m, input logic s,
                      input logic d, input logic t);
    rst = r; alarm_armed = a; time_match = m; snooze_req = s; dismiss_req = d; tick_1hz = t;
    @(posedge clk);
    @(negedge clk);
    snooze_req = 1'b0; dismiss_req = 1'b0; tick_1hz = 1'b0;
  endtask

  // n seconds of 10-clk tick period with armed=1, match held at m.
  task automatic seconds(input int n, input logic m);
    for (int i = 0; i < n; i++) begin
      repeat (9) step(1'b1, 1'b1, m, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, m, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; alarm_armed = 1'b1; time_match = 1'b0;
    snooze_req = 1'b0; dismiss_req = 1'b0; tick_1hz = 1'b0;
    @(negedge clk);

    //                 rst   arm   mat   snz   dis   tick  exp
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010)); // reset
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010)); // trigger
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010_010)); // beep off
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110_010)); // beep on
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000_010)); // dismiss
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010)); // no re-ring
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010)); // new edge
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000_010)); // snz+dis
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b001_001)); // snooze on timeout tick
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b001_001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001_001)); // snooze ignored
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010)); // disarm in snooze
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010)); // edge while disarmed
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000_010)); // disarm in ringing
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001_001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000_010)); // dismiss in snooze
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000_010));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110_010));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010)); // reset mid-ring
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010)); // match held over reset
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000_010));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].armed, vecs[i].match, vecs[i].snz, vecs[i].dis, vecs[i].tick);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Manual snooze twice, full 60 s snooze period, third snooze ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("seq2_ring", 6'b110_010);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("seq2_snz1", 6'b001_001);
    seconds(59, 1'b1);
    check("seq2_snz1_59s", 6'b001_001);
    seconds(1, 1'b1);
    check("seq2_rering1", 6'b110_001);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("seq2_snz2", 6'b001_000);
    seconds(60, 1'b1);
    check("seq2_rering2", 6'b110_000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("seq2_snz_ignored", 6'b110_000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("seq2_dismiss", 6'b000_010);

    // Unattended: two timeouts into snooze, third timeout ends the event.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("seq3_ring", 6'b110_010);
    seconds(3, 1'b1);
    check("seq3_3ticks", 6'b010_010);
    seconds(1, 1'b1);
    check("seq3_to1", 6'b001_001);
    seconds(60, 1'b1);
    check("seq3_rering1", 6'b110_001);
    seconds(4, 1'b1);
    check("seq3_to2", 6'b001_000);
    seconds(60, 1'b1);
    check("seq3_rering2", 6'b110_000);
    seconds(3, 1'b1);
    check("seq3_still", 6'b010_000);
    seconds(1, 1'b1);
    check("seq3_to3_idle", 6'b000_010);
    seconds(2, 1'b1);
    check("seq3_no_rering", 6'b000_010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ring_controller.md
# alarm_ring_controller

Sequences the alarm event for the digital alarm clock: detects the start of an alarm-time match, drives the buzzer beep pattern, and handles snooze, dismiss and unattended timeout. Sits between the time/alarm comparator output and the buzzer/LED pins. It replaces the "any button exits ringing" behaviour with a counted snooze/timeout schedule. All logic runs on the system clock, with one-cycle strobes from the existing divider and button detectors.

## Interface
- SNOOZE_MIN, 5: snooze length in minutes (1–60)
- RING_TIMEOUT_S, 60: seconds of unattended ringing before auto-snooze/stop (1–255)
- MAX_SNOOZES, 3: snoozes allowed per alarm event (1–7)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- tick_1hz  in  1  one-clk-wide strobe once per second
- alarm_armed  in  1  level; alarm function enabled
- time_match  in  1  level; high while clock HH:MM equals alarm HH:MM (a full minute)
- snooze_req  in  1  one-clk debounced pulse
- dismiss_req  in  1  one-clk debounced pulse
- buzzer  out  1  beep drive
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- snoozes_left  out  3  MAX_SNOOZES minus snoozes used in the current event

## Operation
- States: IDLE, RINGING, SNOOZE. All outputs are registered.
- Trigger is a rising edge of time_match: time_match=1 with prev_match=0, where prev_match is time_match registered.
- IDLE -> RINGING on trigger when alarm_armed=1. Without a new edge, a dismissed alarm does not re-ring within the same matching minute.
- On RINGING entry: ring_cnt=0, beep_phase=1.
- RINGING:
  - dismiss_req -> IDLE.
  - Else snooze_req with snoozes_left>0 -> SNOOZE; snoozes_left decrements.
  - snooze_req with snoozes_left=0 is ignored; the user must dismiss.
  - Each tick toggles beep_phase and increments ring_cnt.
  - A tick with ring_cnt=RING_TIMEOUT_S-1 is the timeout. With snoozes_left>0 -> SNOOZE and decrement. With snoozes_left=0 -> IDLE.
- SNOOZE:
  - On entry snz_cnt=0 (16-bit). Each tick increments it.
  - A tick with snz_cnt=SNOOZE_MIN*60-1 -> RINGING.
  - dismiss_req -> IDLE. snooze_req is ignored.
- buzzer = beep_phase in RINGING, else 0. This gives 1 s on / 1 s off, starting on.
- snoozes_left reloads to MAX_SNOOZES on every IDLE entry and at reset. It never underflows.
- alarm_armed=0 forces IDLE from any state on the next clk. It overrides all other inputs.
- A trigger edge seen while in RINGING or SNOOZE is ignored.
- Priority in one cycle: alarm_armed=0 > dismiss_req > snooze_req > tick (timeout/expiry).
- A request coinciding with a tick takes effect, and that tick is not counted.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE; buzzer=0, ringing=0, snoozing=0; snoozes_left=MAX_SNOOZES; counters=0; beep_phase=0.
- prev_match resets to 1. If time_match is already high at reset release, no trigger occurs.
- Trigger sampled at edge N -> ringing=1 and buzzer=1 after edge N+1 (latency 1 clk).
- A request pulse at edge N -> new state and outputs visible after edge N+1.
- Ring timeout: the RING_TIMEOUT_S-th tick after RINGING entry causes the exit. The exit is visible 1 clk after that tick.
- Snooze expiry: the SNOOZE_MIN*60-th tick after SNOOZE entry causes RINGING, 1 clk later.
- Reset mid-event aborts immediately, with no buzzer glitch past the reset edge.

## Test plan
Bench parameters: SNOOZE_MIN=1, RING_TIMEOUT_S=4, MAX_SNOOZES=2. tick_1hz is a strobe every 10 clk.
1. Arm, raise time_match -> ringing=1, buzzer=1 one clk later. Buzzer toggles on each tick. Dismiss -> IDLE; buzzer=0 next clk. time_match stays high and there is no re-ring.
2. Ringing, snooze_req -> snoozing=1, snoozes_left=1. After 60 ticks -> ringing=1. Second snooze -> snoozes_left=0. Third snooze_req while ringing is ignored; ringing stays 1.
3. Unattended ringing -> after the 4th tick, SNOOZE (snoozes_left 2->1). Repeat until snoozes_left=0; the next 4-tick timeout -> IDLE with snoozes_left=2.
4. snooze_req and dismiss_req in the same clk while ringing -> IDLE, snoozes_left=2. snooze_req coincident with the timeout tick -> SNOOZE, and snoozes_left decrements only once.
5. alarm_armed dropped during SNOOZE and during RINGING -> IDLE next clk, buzzer=0. Raising time_match while alarm_armed=0 -> stays IDLE.
6. Hold time_match=1 through reset release -> no ring. Apply rst=0 mid-RINGING -> all outputs at reset values after that edge.
